// File: rtl/gi_gate_ctrl.sv
// Gated-integrator window controller: on a trigger, skips a programmed number
// of ADC samples, forwards a gate of samples to an external integrator, then
// captures the integrator sum into a result register with a ready/valid handshake.
//
// state    | meaning
// IDLE     | waiting for trig, shadows may be reloaded
// DELAY    | counting din_vld pulses before the gate opens
// GATE     | forwarding samples to the integrator
// WAIT_SUM | waiting up to 16 cycles for gi_valid
// HOLDOFF  | dead time before re-arming
module gi_gate_ctrl #(
  parameter int P_NBITS_DATA_IN  = 14,
  parameter int P_NBITS_DATA_OUT = 20,
  parameter int P_NBITS_ADDR     = 6,
  parameter int P_NBITS_DLY      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [P_NBITS_DLY-1:0]      cfg_delay,
  input  logic [P_NBITS_ADDR-1:0]     cfg_gate,
  input  logic [P_NBITS_DLY-1:0]      cfg_holdoff,
  input  logic                        cfg_load,
  input  logic                        trig,
  input  logic                        din_vld,
  input  logic [P_NBITS_DATA_IN-1:0]  din,
  output logic [P_NBITS_ADDR-1:0]     gi_n,
  output logic                        gi_wr,
  output logic [P_NBITS_DATA_IN-1:0]  gi_d,
  input  logic [P_NBITS_DATA_OUT-1:0] gi_sum,
  input  logic                        gi_valid,
  output logic [P_NBITS_DATA_OUT-1:0] res_data,
  output logic                        res_vld,
  input  logic                        res_rdy,
  output logic                        busy,
  output logic [7:0]                  drop_cnt,
  output logic                        tmo
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DELAY    = 3'd1;
  localparam logic [2:0] S_GATE     = 3'd2;
  localparam logic [2:0] S_WAIT_SUM = 3'd3;
  localparam logic [2:0] S_HOLDOFF  = 3'd4;

  // gi_valid must arrive within 16 WAIT_SUM cycles (timer runs 15..0)
  localparam logic [3:0] C_TMO_LOAD = 4'd15;
  localparam logic [P_NBITS_DLY-1:0]  C_DLY_ONE  = P_NBITS_DLY'(1);
  localparam logic [P_NBITS_ADDR-1:0] C_GATE_ONE = P_NBITS_ADDR'(1);
  localparam logic [P_NBITS_ADDR-1:0] C_GATE_RST = P_NBITS_ADDR'(16);

  logic [2:0]              state;
  logic [P_NBITS_DLY-1:0]  sh_delay, sh_holdoff, cap_delay, cap_holdoff, dly_cnt;
  logic [P_NBITS_ADDR-1:0] sh_gate, cap_gate, gate_cnt;
  logic [3:0]              tmr_cnt;
  logic                    pend, trig_q;
  logic                    in_idle, fwd, capture, drop_trig, drop_res, drop_ev;

  assign in_idle   = (state == S_IDLE);
  assign busy      = ~in_idle;
  assign gi_n      = sh_gate;
  assign fwd       = (state == S_GATE) & din_vld;
  assign capture   = (state == S_WAIT_SUM) & gi_valid;
  // In IDLE a zero-length gate rejects the trigger level; elsewhere only new edges count
  assign drop_trig = in_idle ? (trig & (sh_gate == '0)) : (trig & ~trig_q);
  assign drop_res  = capture & res_vld & ~res_rdy;
  assign drop_ev   = drop_trig | drop_res;

  // Shadow configuration: direct load in IDLE, otherwise park it until IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_delay    <= '0;
      sh_gate     <= C_GATE_RST;
      sh_holdoff  <= '0;
      cap_delay   <= '0;
      cap_gate    <= '0;
      cap_holdoff <= '0;
      pend        <= 1'b0;
    end else if (cfg_load && in_idle) begin
      sh_delay   <= cfg_delay;
      sh_gate    <= cfg_gate;
      sh_holdoff <= cfg_holdoff;
      pend       <= 1'b0;
    end else if (cfg_load) begin
      cap_delay   <= cfg_delay;
      cap_gate    <= cfg_gate;
      cap_holdoff <= cfg_holdoff;
      pend        <= 1'b1;
    end else if (pend && in_idle) begin
      sh_delay   <= cap_delay;
      sh_gate    <= cap_gate;
      sh_holdoff <= cap_holdoff;
      pend       <= 1'b0;
    end
  end

  // Sequencing FSM with down-counters for delay, gate, timeout and holdoff
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      dly_cnt  <= '0;
      gate_cnt <= '0;
      tmr_cnt  <= '0;
      tmo      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (trig && (sh_gate != '0)) begin
            state   <= S_DELAY;
            dly_cnt <= sh_delay;
          end
        end
        S_DELAY: begin
          if (dly_cnt == '0) begin
            state    <= S_GATE;
            gate_cnt <= sh_gate;
          end else if (din_vld) begin
            dly_cnt <= dly_cnt - C_DLY_ONE;
            if (dly_cnt == C_DLY_ONE) begin
              state    <= S_GATE;
              gate_cnt <= sh_gate;
            end
          end
        end
        S_GATE: begin
          if (din_vld) begin
            gate_cnt <= gate_cnt - C_GATE_ONE;
            if (gate_cnt == C_GATE_ONE) begin
              state   <= S_WAIT_SUM;
              tmr_cnt <= C_TMO_LOAD;
            end
          end
        end
        S_WAIT_SUM: begin
          if (gi_valid) begin
            state   <= S_HOLDOFF;
            dly_cnt <= sh_holdoff;
          end else if (tmr_cnt == '0) begin
            tmo     <= 1'b1;
            state   <= S_HOLDOFF;
            dly_cnt <= sh_holdoff;
          end else begin
            tmr_cnt <= tmr_cnt - 4'd1;
          end
        end
        S_HOLDOFF: begin
          if (dly_cnt == '0) state <= S_IDLE;
          else               dly_cnt <= dly_cnt - C_DLY_ONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sample forwarding to the integrator and trigger edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      gi_wr  <= 1'b0;
      gi_d   <= '0;
      trig_q <= 1'b0;
    end else begin
      gi_wr  <= fwd;
      trig_q <= trig;
      if (fwd) gi_d <= din;
    end
  end

  // Result register, handshake and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data <= '0;
      res_vld  <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      if (capture && (!res_vld || res_rdy)) begin
        res_data <= gi_sum;
        res_vld  <= 1'b1;
      end else if (res_vld && res_rdy) begin
        res_vld <= 1'b0;
      end
      if (drop_ev && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
